// File: rtl/bis_pkg.sv
// rtl/bis_pkg.sv - shared width default, index-width derivation and FSM state type for the serializer.
package bis_pkg;

  localparam int BIS_W = 32;

  function automatic int bis_idxw(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } bis_state_e;

endpackage

// File: rtl/lsb_index_enc.sv
// rtl/lsb_index_enc.sv - combinational lowest-set-bit encoder built as a balanced priority tree.
module lsb_index_enc
  import bis_pkg::*;
#(
  parameter  int W    = BIS_W,
  localparam int IDXW = bis_idxw(W)
) (
  input  logic [W-1:0]    vec_i,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  // Heap layout: node n has children 2n (lower half) and 2n+1 (upper half); leaf W+b is bit b.
  logic [2*W-1:1]            any_n;
  logic [2*W-1:1][IDXW-1:0]  idx_n;
  logic [IDXW-1:0]           hi_bit;

  always_comb begin
    any_n  = '0;
    idx_n  = '0;
    hi_bit = '0;
    for (int b = 0; b < W; b++) begin
      any_n[W+b] = vec_i[b];
    end
    for (int d = IDXW - 1; d >= 0; d--) begin
      for (int k = 0; k < (1 << d); k++) begin
        hi_bit = '0;
        hi_bit[IDXW-1-d] = 1'b1;
        any_n[(1<<d)+k] = any_n[2*((1<<d)+k)] | any_n[2*((1<<d)+k)+1];
        if (any_n[2*((1<<d)+k)]) begin
          idx_n[(1<<d)+k] = idx_n[2*((1<<d)+k)];
        end else if (any_n[2*((1<<d)+k)+1]) begin
          idx_n[(1<<d)+k] = idx_n[2*((1<<d)+k)+1] | hi_bit;
        end else begin
          idx_n[(1<<d)+k] = '0;
        end
      end
    end
  end

  assign idx_o = idx_n[1];
  assign any_o = any_n[1];

endmodule

// File: rtl/bit_index_serializer.sv
// rtl/bit_index_serializer.sv - emits the index of every set bit of a request word, lowest first.
// Optional zero-word beat reporting via BIS_ZERO_REPORT_EN.
module bit_index_serializer
  import bis_pkg::*;
#(
  parameter  int W    = BIS_W,
  localparam int IDXW = bis_idxw(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last
`ifdef BIS_ZERO_REPORT_EN
  ,
  output logic            out_zero
`endif
);

  bis_state_e   state_q, state_d;
  logic [W-1:0] work_q, work_d, work_rest;
  logic         enc_any, st_emit, load_emit, take_in, take_out;

  lsb_index_enc #(.W(W)) u_enc (
    .vec_i (work_q),
    .idx_o (out_idx),
    .any_o (enc_any)
  );

  assign st_emit   = (state_q == ST_EMIT);
  assign work_rest = work_q & (work_q - {{(W-1){1'b0}}, 1'b1});
  assign out_last  = st_emit && (work_rest == '0);

`ifdef BIS_ZERO_REPORT_EN
  // An empty work register in EMIT is the single zero-report beat.
  assign out_valid = st_emit;
  assign out_zero  = st_emit && !enc_any;
  assign load_emit = 1'b1;
`else
  assign out_valid = st_emit && enc_any;
  assign load_emit = |in_data;
`endif

  // A new word may only land on the final beat so the next word follows without a bubble.
  assign in_ready = !st_emit || (out_ready && out_last);
  assign take_in  = in_valid && in_ready;
  assign take_out = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    if (take_out) begin
      work_d = work_rest;
      if (out_last) begin
        state_d = ST_IDLE;
      end
    end
    if (take_in) begin
      work_d  = in_data;
      state_d = load_emit ? ST_EMIT : ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
    end
  end

endmodule

// File: tb/tb_bit_index_serializer.sv
// tb/tb_bit_index_serializer.sv - self-checking bench for bit_index_serializer.
module tb_bit_index_serializer;

  localparam int W    = 32;
  localparam int IDXW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
`ifdef BIS_ZERO_REPORT_EN
  logic            out_zero;
`endif

  always #5 clk = ~clk;

  bit_index_serializer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef BIS_ZERO_REPORT_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  typedef struct { int idx; bit last; bit zero; } beat_t;
  typedef struct { logic [31:0] word; int n; int first; int fin; } vec_t;

  beat_t           exp_q[$];
  int              obs_q[$];
  int              tests = 0;
  int              fails = 0;
  bit              prev_stall = 1'b0;
  logic [IDXW-1:0] prev_idx;
  logic            prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a word yields its set-bit positions in ascending order, last on the highest one.
  task automatic push_word(input logic [W-1:0] w);
    beat_t bt;
    for (int b = 0; b < W; b++) begin
      if (w[b]) begin
        bt.idx  = b;
        bt.last = ((w >> (b + 1)) == 0);
        bt.zero = 1'b0;
        exp_q.push_back(bt);
      end
    end
`ifdef BIS_ZERO_REPORT_EN
    if (w == 0) begin
      bt.idx = 0; bt.last = 1'b1; bt.zero = 1'b1;
      exp_q.push_back(bt);
    end
`endif
  endtask

  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy);
    logic ev, eir;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    ev  = (exp_q.size() != 0);
    eir = !ev || (ordy && exp_q.size() == 1);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, eir);
    if (ev) begin
      chk("out_idx", out_idx, exp_q[0].idx);
      chk("out_last", out_last, exp_q[0].last);
`ifdef BIS_ZERO_REPORT_EN
      chk("out_zero", out_zero, exp_q[0].zero);
`endif
    end else begin
      chk("idle_last", out_last, 0);
      chk("idle_idx", out_idx, 0);
    end
    if (prev_stall && ev) begin
      chk("stall_idx", out_idx, prev_idx);
      chk("stall_last", out_last, prev_last);
    end
    prev_stall = ev && !ordy;
    prev_idx   = out_idx;
    prev_last  = out_last;
    if (ev && ordy) void'(exp_q.pop_front());
    if (out_valid && ordy) obs_q.push_back(int'(out_idx));
    if (iv && eir) push_word(id);
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      cyc(1'b0, '0, 1'b1);
      c++;
    end
  endtask

  initial begin
    vec_t        tbl[7];
    logic [31:0] w;
    logic        iv, ordy, acc_now;
    int          acc, cycles, pop_total;

    tbl[0] = '{32'h0000_0029, 3, 0, 5};
    tbl[1] = '{32'h8000_0000, 1, 31, 31};
    tbl[2] = '{32'h0000_0001, 1, 0, 0};
    tbl[3] = '{32'h0000_0F00, 4, 8, 11};
    tbl[4] = '{32'h0001_0001, 2, 0, 16};
    tbl[5] = '{32'hFFFF_FFFF, 32, 0, 31};
`ifdef BIS_ZERO_REPORT_EN
    tbl[6] = '{32'h0000_0000, 1, 0, 0};
`else
    tbl[6] = '{32'h0000_0000, 0, 0, 0};
`endif

    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      obs_q.delete();
      cyc(1'b1, tbl[i].word, 1'b1);
      drain(64);
      cyc(1'b0, '0, 1'b1);
      chk("tbl_count", obs_q.size(), tbl[i].n);
      if (obs_q.size() != 0) begin
        chk("tbl_first", obs_q[0], tbl[i].first);
        chk("tbl_final", obs_q[obs_q.size()-1], tbl[i].fin);
      end
    end

    // All ones with out_ready toggling every cycle.
    obs_q.delete();
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1'b0, '0, (i % 2) != 0);
    cyc(1'b0, '0, 1'b1);
    chk("ones_count", obs_q.size(), 32);
    for (int j = 0; j < 32 && j < obs_q.size(); j++) chk("ones_seq", obs_q[j], j);

    // Back-to-back words with no idle cycle between them.
    obs_q.delete();
    cyc(1'b1, 32'h8000_0000, 1'b1);
    cyc(1'b1, 32'h0000_0006, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("b2b_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("b2b_0", obs_q[0], 31);
      chk("b2b_1", obs_q[1], 1);
      chk("b2b_2", obs_q[2], 2);
    end

    // Reset in the middle of a word.
    obs_q.delete();
    cyc(1'b1, 32'h0000_0F00, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_last", out_last, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'h0000_0001, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("midrst_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("midrst_0", obs_q[0], 8);
      chk("midrst_1", obs_q[1], 9);
      chk("midrst_2", obs_q[2], 0);
    end

    // Random words, random valid and backpressure.
    obs_q.delete();
    acc = 0;
    cycles = 0;
    pop_total = 0;
    w = $urandom;
    while (acc < 1000 && cycles < 60000) begin
      iv      = ($urandom_range(0, 3) != 0);
      ordy    = ($urandom_range(0, 3) != 0);
      acc_now = iv && (exp_q.size() == 0 || (ordy && exp_q.size() == 1));
      cyc(iv, w, ordy);
      cycles++;
      if (acc_now) begin
        acc++;
        pop_total += $countones(w);
`ifdef BIS_ZERO_REPORT_EN
        if (w == 0) pop_total++;
`endif
        case ($urandom_range(0, 7))
          0:       w = '0;
          1:       w = 32'h1 << $urandom_range(0, 31);
          2:       w = $urandom;
          default: w = $urandom & $urandom & $urandom;
        endcase
      end
    end
    drain(64);
    cyc(1'b0, '0, 1'b1);
    chk("rand_words", acc, 1000);
    chk("rand_beats", obs_q.size(), pop_total);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
